// File: rtl/sm83_bus_initiator.sv
//==============================================================================
// Module   : sm83_bus_initiator
// Brief    : SM83 external memory bus initiator. Queues read/write commands
//            in a small FIFO and runs each one as a fixed 4-T-state M-cycle
//            (T1..T4) on A/D/MREQ/RD/WR. Read data comes back on a one-cycle
//            RSP_VALID strobe.
// Options  : define SM83_BUS_WAIT_EN to let WAIT stretch T3.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module sm83_bus_initiator #(
    parameter int CMD_DEPTH      = 4,
    parameter bit IDLE_ADDR_HOLD = 1'b1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WRITE,
    input  logic [15:0] CMD_ADDR,
    input  logic [7:0]  CMD_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_DATA,
    output logic        BUSY,
    output logic [15:0] A,
    output logic [7:0]  D_OUT,
    output logic        D_OE,
    input  logic [7:0]  D_IN,
    output logic        MREQ,
    output logic        RD,
    output logic        WR,
    input  logic        WAIT
);

    localparam int c_PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(CMD_DEPTH);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_T1   = 3'd1;
    localparam logic [2:0] c_ST_T2   = 3'd2;
    localparam logic [2:0] c_ST_T3   = 3'd3;
    localparam logic [2:0] c_ST_T4   = 3'd4;

    // Command FIFO storage
    logic               r_fifo_write [CMD_DEPTH];
    logic [15:0]        r_fifo_addr  [CMD_DEPTH];
    logic [7:0]         r_fifo_wdata [CMD_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Sequencer and the command currently on the bus
    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic               r_cur_write;
    logic [15:0]        r_cur_addr;
    logic [7:0]         r_dout;
    logic [7:0]         r_rsp_data;

    logic               w_push;
    logic               w_pop;
    logic               w_fifo_empty;
    logic               w_t3_done;

    assign w_fifo_empty = (r_count == '0);
    assign CMD_READY    = (r_count != c_DEPTH);
    assign w_push       = CMD_VALID & CMD_READY;

`ifdef SM83_BUS_WAIT_EN
    // Responder may stretch T3; the stall is sampled on the edge ending T3.
    assign w_t3_done = ~WAIT;
`else
    // WAIT has no effect in this build; T3 always lasts a single cycle.
    assign w_t3_done = 1'b1 | WAIT;
`endif

    // FIFO payload write; storage needs no reset because r_count gates reads.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_write[r_wr_ptr] <= CMD_WRITE;
            r_fifo_addr[r_wr_ptr]  <= CMD_ADDR;
            r_fifo_wdata[r_wr_ptr] <= CMD_WDATA;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // M-cycle state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a command is popped on the edge that enters T1.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_state_next = c_ST_T1;
                    w_pop        = 1'b1;
                end
            end
            c_ST_T1: w_state_next = c_ST_T2;
            c_ST_T2: w_state_next = c_ST_T3;
            c_ST_T3: begin
                if (w_t3_done) begin
                    w_state_next = c_ST_T4;
                end
            end
            c_ST_T4: begin
                if (!w_fifo_empty) begin
                    w_state_next = c_ST_T1;
                    w_pop        = 1'b1;
                end else begin
                    w_state_next = c_ST_IDLE;
                end
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Latch the popped command; address and write data stay put through T4.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_cur_write <= 1'b0;
            r_cur_addr  <= 16'h0000;
            r_dout      <= 8'h00;
        end else if (w_pop) begin
            r_cur_write <= r_fifo_write[r_rd_ptr];
            r_cur_addr  <= r_fifo_addr[r_rd_ptr];
            if (r_fifo_write[r_rd_ptr]) begin
                r_dout <= r_fifo_wdata[r_rd_ptr];
            end
        end
    end

    // Capture read data on the edge leaving T3 (after any wait states).
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rsp_data <= 8'h00;
        end else if ((r_state == c_ST_T3) && w_t3_done && !r_cur_write) begin
            r_rsp_data <= D_IN;
        end
    end

    // Bus strobes decoded from the T-state; RD and WR are mutually exclusive.
    always_comb begin
        MREQ      = (r_state == c_ST_T1) || (r_state == c_ST_T2) || (r_state == c_ST_T3);
        RD        = !r_cur_write && ((r_state == c_ST_T2) || (r_state == c_ST_T3));
        WR        =  r_cur_write && ((r_state == c_ST_T2) || (r_state == c_ST_T3));
        D_OE      =  r_cur_write && (r_state != c_ST_IDLE);
        RSP_VALID = !r_cur_write && (r_state == c_ST_T4);
        BUSY      = !w_fifo_empty || (r_state != c_ST_IDLE);
    end

    assign D_OUT    = r_dout;
    assign RSP_DATA = r_rsp_data;

    generate
        if (IDLE_ADDR_HOLD) begin : g_addr_hold
            assign A = r_cur_addr;
        end else begin : g_addr_clear
            assign A = (r_state == c_ST_IDLE) ? 16'h0000 : r_cur_addr;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sm83_bus_initiator.sv
//==============================================================================
// Module   : tb_sm83_bus_initiator
// Brief    : Scoreboard bench for sm83_bus_initiator. Accepted commands are
//            queued with their expected effect; a negedge monitor checks the
//            bus cycle, strobe timing, handshake and read responses against a
//            reference memory. A second instance runs with IDLE_ADDR_HOLD=0.
// Options  : honours SM83_BUS_WAIT_EN (WAIT stretches T3 only when defined).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sm83_bus_initiator;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_WRITE = 1'b0;
    logic [15:0] CMD_ADDR = 16'h0000;
    logic [7:0]  CMD_WDATA = 8'h00;
    logic        WAIT = 1'b0;
    logic [7:0]  D_IN;

    wire         CMD_READY, RSP_VALID, BUSY, D_OE, MREQ, RD, WR;
    wire  [7:0]  RSP_DATA, D_OUT;
    wire  [15:0] A;

    wire         z_cmd_ready, z_rsp_valid, z_busy, z_d_oe, z_mreq, z_rd, z_wr;
    wire  [7:0]  z_rsp_data, z_d_out;
    wire  [15:0] z_a;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } cmd_t;

    cmd_t        q[$];
    logic [7:0]  ref_mem  [65536];
    logic [7:0]  resp_mem [65536];
    int          n_vec  = 0;
    int          n_fail = 0;
    bit          wait_en = 1'b0;

    sm83_bus_initiator #(.CMD_DEPTH(4), .IDLE_ADDR_HOLD(1'b1)) u_dut (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY), .A(A),
        .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN), .MREQ(MREQ), .RD(RD), .WR(WR),
        .WAIT(WAIT)
    );

    sm83_bus_initiator #(.CMD_DEPTH(4), .IDLE_ADDR_HOLD(1'b0)) u_dut_z (
        .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(z_cmd_ready),
        .CMD_WRITE(CMD_WRITE), .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA),
        .RSP_VALID(z_rsp_valid), .RSP_DATA(z_rsp_data), .BUSY(z_busy), .A(z_a),
        .D_OUT(z_d_out), .D_OE(z_d_oe), .D_IN(D_IN), .MREQ(z_mreq), .RD(z_rd), .WR(z_wr),
        .WAIT(WAIT)
    );

    always #5 CLK = ~CLK;

    // Memory responder: returns its contents while RD is asserted.
    assign D_IN = RD ? resp_mem[A] : 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor / scoreboard state
    int          pushed = 0, started = 0, mreq_run = 0, exp_len = 3, fifo_cnt;
    bit          prev_mreq = 0, prev_wr = 0, chk_next = 0, exp_next = 0, post_reset = 0, t4;
    logic [15:0] last_addr = 16'h0000;
    logic [7:0]  last_rsp = 8'h00;
    cmd_t        cur;

    always @(negedge CLK) begin
        if (RESET) begin
            q.delete();
            pushed = 0; started = 0; mreq_run = 0; exp_len = 3;
            prev_mreq = 0; prev_wr = 0; chk_next = 1; exp_next = 0;
            last_addr = 16'h0000; last_rsp = 8'h00; post_reset = 1;
        end else begin
            if (post_reset) begin
                chk("reset_d_out", {24'h0, D_OUT}, 32'h0);
                chk("reset_z_busy", {31'h0, z_busy}, 32'h0);
                post_reset = 0;
            end
            // Responder latches write data as WR falls.
            if (prev_wr && !WR) resp_mem[A] = D_OUT;
            if (chk_next) chk("mreq_start", {31'h0, MREQ}, {31'h0, exp_next});
            chk("rd_wr_excl", {31'h0, RD & WR}, 32'h0);
            t4 = prev_mreq && !MREQ;
            if (MREQ) begin
                mreq_run++;
                if (mreq_run == 1) started++;
                if (q.size() == 0) begin
                    chk("mreq_without_cmd", {31'h0, MREQ}, 32'h0);
                end else begin
                    cur = q[0];
                    chk("addr", {16'h0, A}, {16'h0, cur.addr});
                    chk("addr_z", {16'h0, z_a}, {16'h0, cur.addr});
                    chk("rd", {31'h0, RD}, {31'h0, (mreq_run >= 2) && !cur.wr});
                    chk("wr", {31'h0, WR}, {31'h0, (mreq_run >= 2) && cur.wr});
                    chk("d_oe", {31'h0, D_OE}, {31'h0, cur.wr});
                    if (cur.wr) chk("d_out", {24'h0, D_OUT}, {24'h0, cur.data});
                end
`ifdef SM83_BUS_WAIT_EN
                if (mreq_run >= 3 && WAIT) exp_len++;
`endif
            end
            fifo_cnt = pushed - started;
            chk("cmd_ready", {31'h0, CMD_READY}, {31'h0, fifo_cnt < 4});
            chk("busy", {31'h0, BUSY}, {31'h0, (fifo_cnt != 0) || MREQ || t4});
            if (t4) begin
                chk("mreq_len", mreq_run, exp_len);
                if (q.size() == 0) begin
                    chk("t4_without_cmd", 32'h1, 32'h0);
                end else begin
                    cur = q.pop_front();
                    chk("t4_addr", {16'h0, A}, {16'h0, cur.addr});
                    chk("t4_strobes", {30'h0, RD, WR}, 32'h0);
                    if (cur.wr) begin
                        chk("t4_d_oe", {31'h0, D_OE}, 32'h1);
                        chk("t4_d_out", {24'h0, D_OUT}, {24'h0, cur.data});
                        chk("t4_rsp_valid", {31'h0, RSP_VALID}, 32'h0);
                        ref_mem[cur.addr] = cur.data;
                    end else begin
                        chk("rsp_valid", {31'h0, RSP_VALID}, 32'h1);
                        chk("rsp_data", {24'h0, RSP_DATA}, {24'h0, ref_mem[cur.addr]});
                        last_rsp = ref_mem[cur.addr];
                    end
                    last_addr = cur.addr;
                end
                mreq_run = 0;
                exp_len = 3;
            end else begin
                chk("rsp_valid_idle", {31'h0, RSP_VALID}, 32'h0);
                chk("rsp_data_hold", {24'h0, RSP_DATA}, {24'h0, last_rsp});
                if (!MREQ) begin
                    chk("d_oe_idle", {31'h0, D_OE}, 32'h0);
                    chk("idle_addr_hold", {16'h0, A}, {16'h0, last_addr});
                    chk("idle_addr_zero", {16'h0, z_a}, 32'h0);
                end
            end
            chk_next = !MREQ;
            exp_next = (fifo_cnt != 0);
            if (CMD_VALID && CMD_READY) begin
                q.push_back('{wr: CMD_WRITE, addr: CMD_ADDR, data: CMD_WDATA});
                pushed++;
            end
            prev_mreq = MREQ;
            prev_wr = WR;
        end
    end

    // Random responder stalls, applied just after each rising edge.
    always @(posedge CLK) begin
        #1 WAIT = wait_en && ($urandom_range(0, 2) == 0);
    end

    task automatic issue(input bit w, input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        CMD_VALID = 1'b1; CMD_WRITE = w; CMD_ADDR = a; CMD_WDATA = d;
        forever begin
            @(negedge CLK);
            if (CMD_READY) break;
            n++;
            if (n > 500) begin
                n_fail++;
                $display("FAIL issue_timeout: CMD_READY stayed 0, expected 1 within 500 cycles");
                break;
            end
        end
        @(posedge CLK); #1;
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        forever begin
            @(negedge CLK);
            if (!BUSY) break;
            n++;
            if (n > 2000) begin
                n_fail++;
                $display("FAIL idle_timeout: BUSY stayed 1, expected 0 within 2000 cycles");
                break;
            end
        end
    endtask

    function automatic logic [15:0] rand_addr();
        logic [7:0] hi;
        case ($urandom_range(0, 3))
            0: hi = 8'hFF;
            1: hi = 8'h80;
            2: hi = 8'h01;
            default: hi = 8'hC0;
        endcase
        return {hi, 4'h0, 4'($urandom_range(0, 15))};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) begin
            ref_mem[i]  = 8'(i ^ (i >> 8) ^ 8'h5A);
            resp_mem[i] = ref_mem[i];
        end
        ref_mem[16'h0150] = 8'h3C; resp_mem[16'h0150] = 8'h3C;
        ref_mem[16'h1234] = 8'hA7; resp_mem[16'h1234] = 8'hA7;

        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;

        // Single read, then back-to-back writes, then read them back.
        issue(1'b0, 16'h0150, 8'h00);
        wait_idle();
        issue(1'b1, 16'hFF01, 8'h55);
        issue(1'b1, 16'hFF02, 8'h81);
        wait_idle();
        chk("resp_mem_ff01", {24'h0, resp_mem[16'hFF01]}, 32'h55);
        chk("resp_mem_ff02", {24'h0, resp_mem[16'hFF02]}, 32'h81);
        issue(1'b0, 16'hFF01, 8'h00);
        issue(1'b0, 16'hFF02, 8'h00);
        wait_idle();

        // Overfill the FIFO while the bus is busy.
        for (int i = 0; i < 8; i++) issue(i[0], rand_addr(), 8'($urandom));
        wait_idle();

        // Reset in T2 of a read of 0x8000.
        issue(1'b0, 16'h8000, 8'h00);
        n = 0;
        while (!(MREQ && !RD) && n < 50) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 50) begin
            n_fail++;
            $display("FAIL t1_timeout: T1 not seen, expected within 50 cycles");
        end
        @(posedge CLK); #1 RESET = 1'b1;
        @(posedge CLK); #1 RESET = 1'b0;
        repeat (3) @(negedge CLK);

        // Randomized traffic with responder stalls.
        wait_en = 1'b1;
        issue(1'b0, 16'h1234, 8'h00);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(posedge CLK);
            #1 issue($urandom_range(0, 1) == 1, rand_addr(), 8'($urandom));
        end
        wait_idle();
        wait_en = 1'b0;
        repeat (5) @(negedge CLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sm83_bus_initiator.md
Name: sm83_bus_initiator

Overview:
- Synthesizable initiator for the SM83 external memory bus (A, D, MREQ, RD, WR); the requester side of the protocol our bus-responder models answer.
- Accepts queued read/write commands and drives each as a fixed 4-T-state M-cycle; returns read data on a response strobe.
- Used to exercise memory/MMIO responders and serial/IF registers without the full SM83Core, and as a DMA-style bus master in later integration.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, 2..16.
- IDLE_ADDR_HOLD, 1, 1: A keeps the last address when idle; 0: A returns to 16'h0000 when idle.

Ports:
- CLK  in  1  single clock; all state changes on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CMD_VALID  in  1  command offered.
- CMD_READY  out  1  FIFO can accept; depends only on the FIFO count (high when count < CMD_DEPTH).
- CMD_WRITE  in  1  1 = write, 0 = read.
- CMD_ADDR  in  16  target address.
- CMD_WDATA  in  8  write data (ignored for reads).
- RSP_VALID  out  1  one-cycle read-completion strobe.
- RSP_DATA  out  8  captured read data; held until the next read completes.
- BUSY  out  1  high when FIFO is non-empty or the FSM is not IDLE.
- A  out  16  address bus.
- D_OUT  out  8  write data to bus.
- D_OE  out  1  D_OUT drive enable (wrapper builds the inout).
- D_IN  in  8  read data from bus.
- MREQ  out  1  memory request, active high.
- RD  out  1  read strobe, active high.
- WR  out  1  write strobe, active high.
- WAIT  in  1  responder stall (used only with the optional feature).

Behaviour:
- Reset (synchronous, active-high): FSM=IDLE, FIFO emptied, A=0000, D_OUT=00, D_OE=0, MREQ=RD=WR=0, RSP_VALID=0, RSP_DATA=00, BUSY=0.
- Reset asserted mid-transaction: everything above takes effect at that edge, including strobes dropping; no RSP_VALID for the aborted read.
- Handshake:
  - A push happens on an edge with CMD_VALID&CMD_READY.
  - Full FIFO: CMD_READY=0 even if a pop occurs in the same cycle.
  - Simultaneous push and pop on a non-full FIFO: count is unchanged.
- FSM states: IDLE -> T1 -> T2 -> T3 -> T4 -> (T1 if FIFO non-empty, else IDLE). Each state lasts one CLK.
- Command pop: on the edge entering T1. A command pushed into an empty FIFO while IDLE sees T1 in the next cycle (1-cycle latency). Back-to-back commands have no idle gap.
- Read cycle:
  - T1: A=addr, MREQ=1.
  - T2, T3: MREQ=1, RD=1.
  - D_IN captured into RSP_DATA on the edge leaving T3.
  - T4: MREQ=0, RD=0, RSP_VALID=1.
- Write cycle:
  - T1: A=addr, MREQ=1, D_OUT=wdata, D_OE=1.
  - T2, T3: WR=1 additionally.
  - T4: WR=0, MREQ=0; A, D_OUT and D_OE held so responders sampling on WR's falling edge see stable address and data.
  - D_OE=0 after T4, unless the next cycle is a write.
- RD and WR are never high together. MREQ is never high in IDLE or T4.
- Idle address: A follows IDLE_ADDR_HOLD.
- FIFO pointers: log2(CMD_DEPTH) bits, wrap modulo CMD_DEPTH. Count is log2(CMD_DEPTH)+1 bits.

Optional Feature:
- Macro: SM83_BUS_WAIT_EN.
- Defined: WAIT is sampled on each edge at the end of T3. If WAIT=1, the FSM stays in T3 with strobes held, and read capture is deferred to the edge on which WAIT=0. The wait can last an unbounded number of cycles; reset still aborts it.
- Undefined: WAIT is ignored; T3 is always one cycle.

Test Plan:
- Reset then single read of 0x0150 with responder returning 0x3C -> MREQ high T1-T3, RD high T2-T3, RSP_VALID one cycle in T4 with RSP_DATA=3C; RSP_DATA remains 3C afterwards.
- Write 0x55 to 0xFF01, then write 0x81 to 0xFF02 back-to-back -> two 4-cycle M-cycles with no gap; WR falls while A=FF02 and D_OUT=81 are still driven; the responder captures both bytes.
- Push 5 commands with CMD_DEPTH=4 while BUSY -> CMD_READY=0 after the 4th accept; the 5th is accepted only after a pop; all 5 execute in order.
- RESET asserted during T2 of a read of 0x8000 -> strobes and MREQ low at the next edge; no RSP_VALID; FIFO empty; BUSY=0.
- With SM83_BUS_WAIT_EN: WAIT high for 3 cycles in T3 of a read returning 0xA7 -> RD high for 5 cycles total; RSP_DATA=A7. Without the macro, the same stimulus gives RD high for 2 cycles.
- IDLE_ADDR_HOLD=0: after a read of 0x1234 completes -> A=0000 in IDLE; with the default (1), A stays 1234.
